note_sequencer: RTL

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/note_sequencer.sv
// Rhythm-game note scheduler: LFSR note spawning, per-lane pending masks, hit/near/miss judgement and scoring.
// Optional combo bonus scoring is built when NOTE_SEQUENCER_COMBO_EN is defined.
module note_sequencer #(
   parameter int unsigned TICK_DIV   = 512,
   parameter int unsigned SONG_TICKS = 128,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic       clk,
   input  logic       RSTn,
   input  logic       start,
   input  logic       pause,
   input  logic [3:0] KEY,
   output logic [3:0] spawn,
   output logic       scroll_tick,
   output logic [3:0] hit,
   output logic [3:0] near,
   output logic [3:0] miss,
   output logic [7:0] score,
   output logic       playing,
   output logic       done
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
   localparam logic [15:0] SONG_LEN  = 16'(SONG_TICKS);

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
   endfunction

   state_t          r_state, w_state_nxt;
   logic            w_load, w_run, w_tick, w_song_end, w_pend_empty;
   logic [15:0]     r_tick_cnt, r_song_cnt, r_lfsr;
   logic [3:0][7:0] r_pend, w_pend_clr, w_pend_nxt;
   logic [3:0]      w_key, w_spawn, w_hit, w_near, w_miss;
   logic [3:0]      r_spawn, r_hit, r_near, r_miss;
   logic            r_scroll_tick, r_playing, r_done;
   logic [3:0]      w_inc;
   logic [2:0]      w_judged;
   logic [8:0]      w_score_sum;
   logic [7:0]      r_score, w_score_nxt;
`ifdef NOTE_SEQUENCER_COMBO_EN
   logic [7:0]      r_combo, w_combo_nxt;
   logic [8:0]      w_combo_sum;
`endif

   assign w_song_end   = (r_song_cnt >= SONG_LEN);
   assign w_pend_empty = (r_pend == '0);

   // Next-state decode; a song (re)start reloads all play state.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = S_PLAY;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = r_state;
            end
         end
         S_PLAY: begin
            if (w_song_end && w_pend_empty) begin
               w_state_nxt = S_DONE;
            end else if (pause) begin
               w_state_nxt = S_PAUSE;
            end else begin
               w_state_nxt = S_PLAY;
            end
         end
         S_PAUSE: begin
            if (!pause) begin
               w_state_nxt = S_PLAY;
            end else begin
               w_state_nxt = S_PAUSE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Play logic only advances in cycles that stay in PLAY, so pause freezes immediately.
   assign w_run   = (r_state == S_PLAY) && (w_state_nxt == S_PLAY);
   assign w_tick  = w_run && (r_tick_cnt == TICK_LAST);
   assign w_spawn = (w_tick && !w_song_end && !r_song_cnt[0]) ? r_lfsr[3:0] : 4'd0;
   assign w_key   = w_run ? KEY : 4'd0;

   // Judgement clears before the scroll shift, so a judged bit never moves down the lane.
   always_comb begin
      w_hit      = 4'd0;
      w_near     = 4'd0;
      w_miss     = 4'd0;
      w_pend_clr = '0;
      w_pend_nxt = '0;
      w_inc      = 4'd0;
      w_judged   = 3'd0;
      for (int l = 0; l < 4; l++) begin
         w_hit[l]      = w_key[l] & r_pend[l][7];
         w_near[l]     = w_key[l] & ~r_pend[l][7] & r_pend[l][6];
         w_pend_clr[l] = r_pend[l] & ~{w_hit[l], w_near[l], 6'd0};
         w_miss[l]     = w_tick & w_pend_clr[l][7];
         w_pend_nxt[l] = w_tick ? {w_pend_clr[l][6:0], w_spawn[l]} : w_pend_clr[l];
         if (w_hit[l]) begin
            w_inc    = w_inc + 4'd2;
            w_judged = w_judged + 3'd1;
         end else if (w_near[l]) begin
            w_inc    = w_inc + 4'd1;
            w_judged = w_judged + 3'd1;
         end else begin
            w_inc    = w_inc;
            w_judged = w_judged;
         end
      end
`ifdef NOTE_SEQUENCER_COMBO_EN
      w_combo_sum = {1'b0, r_combo} + {6'd0, w_judged};
      if (r_combo >= 8'd8) begin
         w_inc = w_inc + {1'b0, w_judged};
      end else begin
         w_inc = w_inc;
      end
      if (|w_miss) begin
         w_combo_nxt = 8'd0;
      end else if (w_combo_sum[8]) begin
         w_combo_nxt = 8'hFF;
      end else begin
         w_combo_nxt = w_combo_sum[7:0];
      end
`endif
      w_score_sum = {1'b0, r_score} + {5'd0, w_inc};
      w_score_nxt = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
   end

   // State register and status flags aligned with it.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         r_state   <= S_IDLE;
         r_playing <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_playing <= (w_state_nxt == S_PLAY) || (w_state_nxt == S_PAUSE);
         r_done    <= (w_state_nxt == S_DONE);
      end
   end

   // Counters, LFSR, pending masks, score and pulse outputs.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         r_tick_cnt    <= 16'd0;
         r_song_cnt    <= 16'd0;
         r_lfsr        <= SEED;
         r_pend        <= '0;
         r_score       <= 8'd0;
         r_spawn       <= 4'd0;
         r_hit         <= 4'd0;
         r_near        <= 4'd0;
         r_miss        <= 4'd0;
         r_scroll_tick <= 1'b0;
`ifdef NOTE_SEQUENCER_COMBO_EN
         r_combo       <= 8'd0;
`endif
      end else if (w_load) begin
         r_tick_cnt    <= 16'd0;
         r_song_cnt    <= 16'd0;
         r_lfsr        <= SEED;
         r_pend        <= '0;
         r_score       <= 8'd0;
         r_spawn       <= 4'd0;
         r_hit         <= 4'd0;
         r_near        <= 4'd0;
         r_miss        <= 4'd0;
         r_scroll_tick <= 1'b0;
`ifdef NOTE_SEQUENCER_COMBO_EN
         r_combo       <= 8'd0;
`endif
      end else if (w_run) begin
         r_tick_cnt    <= w_tick ? 16'd0 : r_tick_cnt + 16'd1;
         r_song_cnt    <= (w_tick && !w_song_end) ? r_song_cnt + 16'd1 : r_song_cnt;
         r_lfsr        <= w_tick ? lfsr_next(r_lfsr) : r_lfsr;
         r_pend        <= w_pend_nxt;
         r_score       <= w_score_nxt;
         r_spawn       <= w_spawn;
         r_hit         <= w_hit;
         r_near        <= w_near;
         r_miss        <= w_miss;
         r_scroll_tick <= w_tick;
`ifdef NOTE_SEQUENCER_COMBO_EN
         r_combo       <= w_combo_nxt;
`endif
      end else begin
         r_spawn       <= 4'd0;
         r_hit         <= 4'd0;
         r_near        <= 4'd0;
         r_miss        <= 4'd0;
         r_scroll_tick <= 1'b0;
      end
   end

   assign spawn       = r_spawn;
   assign scroll_tick = r_scroll_tick;
   assign hit         = r_hit;
   assign near        = r_near;
   assign miss        = r_miss;
   assign score       = r_score;
   assign playing     = r_playing;
   assign done        = r_done;
endmodule
